component_reg_access_ctrl: RTL and testbench

Owns the component register bank (memory_offset, stat_depth, stat_width, version) as a flat vector and arbitrates 32-bit read/write accesses to it from NUM_REQ requesters, round-robin.
- Applies READ_MASK on reads and WRITE_MASK on writes.
- Drives the full register vector to the datapath.
- Sits between host/debug access ports and the component datapath.

---
 rtl/component_reg_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_component_reg_access_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/component_reg_access_ctrl.sv
// Component register bank with round-robin 32-bit word access from NUM_REQ
// requesters. One transaction in flight: accept (IDLE) -> ACCESS -> RESP.
module component_reg_access_ctrl #(
  parameter int unsigned              NUM_REQ       = 2,
  parameter int unsigned              REGISTER_BITS = 64,
  parameter logic [REGISTER_BITS-1:0] READ_MASK     = '1,
  parameter logic [REGISTER_BITS-1:0] WRITE_MASK    = {{(REGISTER_BITS-32){1'b1}}, 32'h0},
  parameter logic [REGISTER_BITS-1:0] RESET_VALUE   = '0,
  parameter int unsigned              ADDR_BITS     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_BITS-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]        req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [31:0]                  rsp_rdata,
  output logic                         rsp_error,
  output logic [REGISTER_BITS-1:0]     regs_out
);

  localparam int unsigned NUM_WORDS = REGISTER_BITS / 32;
  localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if ((REGISTER_BITS % 32) != 0 || REGISTER_BITS == 0) begin : g_bad_width
    $error("REGISTER_BITS must be a non-zero multiple of 32");
  end
  if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 1..8");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                   state, state_next;
  logic [IDX_W-1:0]         rr_ptr;
  logic [IDX_W-1:0]         win_idx;
  logic [IDX_W-1:0]         arb_idx;
  logic                     arb_found;
  int unsigned              cand;
  logic                     lat_write;
  logic [ADDR_BITS-1:0]     lat_addr;
  logic [31:0]              lat_wdata;
  logic [REGISTER_BITS-1:0] regs, regs_next;
  logic [31:0]              sel_word, sel_rmask, sel_wmask;
  logic                     addr_hit;
  logic [31:0]              rdata_q;
  logic                     error_q;
  logic                     rsp_hs;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(rr_ptr) + i) % NUM_REQ;
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, accept strobe and response valid.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_hs     = 1'b0;
    case (state)
      IDLE: begin
        if (arb_found && !rst) begin
          req_ready[arb_idx] = 1'b1;
          state_next         = ACCESS;
        end
      end
      ACCESS: state_next = RESP;
      RESP: begin
        rsp_valid[win_idx] = 1'b1;
        if (rsp_ready[win_idx]) begin
          rsp_hs     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Select the addressed word and its masks; addr_hit clear means out of range.
  always_comb begin
    sel_word  = '0;
    sel_rmask = '0;
    sel_wmask = '0;
    addr_hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (32'(lat_addr) == k) begin
        sel_word  = regs[32*k +: 32];
        sel_rmask = READ_MASK[32*k +: 32];
        sel_wmask = WRITE_MASK[32*k +: 32];
        addr_hit  = 1'b1;
      end
    end
  end

  // Masked write merge, only in ACCESS for an in-range write.
  always_comb begin
    regs_next = regs;
    if (state == ACCESS && lat_write && addr_hit) begin
      for (int unsigned k = 0; k < NUM_WORDS; k++) begin
        if (32'(lat_addr) == k)
          regs_next[32*k +: 32] = (sel_word & ~sel_wmask) | (lat_wdata & sel_wmask);
      end
    end
  end

  // Datapath: register bank, request latch, response data, rr pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs      <= RESET_VALUE;
      rr_ptr    <= '0;
      win_idx   <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      regs <= regs_next;
      if (state == IDLE && arb_found) begin
        win_idx   <= arb_idx;
        lat_write <= req_write[arb_idx];
        lat_addr  <= req_addr[arb_idx*ADDR_BITS +: ADDR_BITS];
        lat_wdata <= req_wdata[arb_idx*32 +: 32];
      end
      if (state == ACCESS) begin
        error_q <= !addr_hit;
        rdata_q <= (addr_hit && !lat_write) ? (sel_word & sel_rmask) : '0;
      end
      if (rsp_hs)
        rr_ptr <= (32'(win_idx) + 1 == NUM_REQ) ? '0 : win_idx + 1'b1;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;
  assign regs_out  = regs;

endmodule

// File: tb/tb_component_reg_access_ctrl.sv
// Bench for component_reg_access_ctrl: table of directed transactions,
// round-robin / stall / reset-abort sequences, then randomized traffic
// checked against a transaction-level model of the register bank.
module tb_component_reg_access_ctrl;

  localparam int NR = 2;
  localparam int AB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid, rsp_ready;
  logic [NR*AB-1:0]  req_addr;
  logic [NR*32-1:0]  req_wdata;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;
  logic [63:0]       regs_out;

  always #5 clk = ~clk;

  component_reg_access_ctrl #(
    .NUM_REQ      (NR),
    .REGISTER_BITS(64),
    .ADDR_BITS    (AB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .regs_out (regs_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Per-requester request contents.
  logic          t_write[NR];
  logic [AB-1:0] t_addr[NR];
  logic [31:0]   t_wdata[NR];

  // Model: word 0 = version (read-only), word 1 = fully writable, 2 words.
  logic [31:0] m_word[2];
  int          m_rr;

  typedef struct {
    int          req;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          exp_win;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [63:0] exp_regs;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [NR-1:0] vmask);
    req_valid = vmask;
    for (int i = 0; i < NR; i++) begin
      req_write[i]           = t_write[i];
      req_addr[i*AB +: AB]   = t_addr[i];
      req_wdata[i*32 +: 32]  = t_wdata[i];
    end
  endtask

  function automatic int model_winner(input logic [NR-1:0] vmask);
    for (int i = 0; i < NR; i++) begin
      int c;
      c = (m_rr + i) % NR;
      if (vmask[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_exec(input int w, output logic [31:0] rd, output logic err);
    int a;
    a = int'(t_addr[w]);
    rd  = '0;
    err = 1'b0;
    if (a >= 2) err = 1'b1;
    else if (t_write[w]) begin
      if (a == 1) m_word[1] = t_wdata[w];
    end else rd = m_word[a];
  endtask

  // One full transaction; entered and left at posedge+1 of an IDLE cycle.
  task automatic txn(input logic [NR-1:0] vmask, input int hold,
                     output int obs_win, output logic [31:0] obs_rdata,
                     output logic obs_err, output logic [63:0] obs_regs);
    int          ew;
    logic [NR-1:0] oh;
    logic [31:0] erd;
    logic        eerr;
    logic [63:0] old_regs;
    apply(vmask);
    ew = model_winner(vmask);
    oh = NR'(1) << ew;
    @(negedge clk);
    obs_win = -1;
    for (int i = 0; i < NR; i++) if (req_ready[i]) obs_win = i;
    check("grant", 64'(req_ready), 64'(oh));
    old_regs = {m_word[1], m_word[0]};
    @(posedge clk); #1;
    apply(vmask & ~oh);
    @(negedge clk);
    check("t1_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t1_regs", regs_out, old_regs);
    check("t1_stall", 64'(req_ready), 64'd0);
    model_exec(ew, erd, eerr);
    @(posedge clk); #1;
    @(negedge clk);
    obs_rdata = rsp_rdata;
    obs_err   = rsp_error;
    obs_regs  = regs_out;
    check("t2_rsp_valid", 64'(rsp_valid), 64'(oh));
    check("t2_rdata", 64'(rsp_rdata), 64'(erd));
    check("t2_error", 64'(rsp_error), 64'(eerr));
    check("t2_regs", regs_out, {m_word[1], m_word[0]});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      rsp_ready = ~oh;
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'(oh));
      check("hold_rdata", 64'(rsp_rdata), 64'(erd));
      check("hold_error", 64'(rsp_error), 64'(eerr));
      check("hold_no_accept", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = '0;
    check("rsp_drop", 64'(rsp_valid), 64'd0);
    m_rr = (ew + 1) % NR;
  endtask

  initial begin
    int          w;
    logic [31:0] rd;
    logic        er;
    logic [63:0] rg;
    logic [NR-1:0] vm;
    int          rr_exp[4];

    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
    for (int i = 0; i < NR; i++) begin
      t_write[i] = 1'b0; t_addr[i] = '0; t_wdata[i] = '0;
    end
    m_word[0] = '0; m_word[1] = '0; m_rr = 0;

    tbl[0] = '{0, 1'b0, 4'd0, 32'h0,         0, 32'h0,         1'b0, 64'h0};
    tbl[1] = '{0, 1'b0, 4'd1, 32'h0,         0, 32'h0,         1'b0, 64'h0};
    tbl[2] = '{1, 1'b1, 4'd1, 32'h1234_5678, 1, 32'h0,         1'b0, 64'h1234_5678_0000_0000};
    tbl[3] = '{1, 1'b0, 4'd1, 32'h0,         1, 32'h1234_5678, 1'b0, 64'h1234_5678_0000_0000};
    tbl[4] = '{0, 1'b1, 4'd0, 32'hDEAD_BEEF, 0, 32'h0,         1'b0, 64'h1234_5678_0000_0000};
    tbl[5] = '{0, 1'b0, 4'd0, 32'h0,         0, 32'h0,         1'b0, 64'h1234_5678_0000_0000};
    tbl[6] = '{1, 1'b0, 4'd2, 32'h0,         1, 32'h0,         1'b1, 64'h1234_5678_0000_0000};
    tbl[7] = '{0, 1'b1, 4'd3, 32'h5555_AAAA, 0, 32'h0,         1'b1, 64'h1234_5678_0000_0000};
    tbl[8] = '{1, 1'b1, 4'd1, 32'hA5A5_0F0F, 1, 32'h0,         1'b0, 64'hA5A5_0F0F_0000_0000};

    // Reset state, including a valid request that must not be accepted.
    @(negedge clk);
    check("rst_regs", regs_out, 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_error", 64'(rsp_error), 64'd0);
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_regs", regs_out, 64'd0);

    // Directed table.
    foreach (tbl[v]) begin
      t_write[tbl[v].req] = tbl[v].wr;
      t_addr[tbl[v].req]  = tbl[v].addr;
      t_wdata[tbl[v].req] = tbl[v].wdata;
      txn(NR'(1) << tbl[v].req, 0, w, rd, er, rg);
      check($sformatf("tbl%0d_win", v), 64'(w), 64'(tbl[v].exp_win));
      check($sformatf("tbl%0d_rdata", v), 64'(rd), 64'(tbl[v].exp_rdata));
      check($sformatf("tbl%0d_err", v), 64'(er), 64'(tbl[v].exp_err));
      check($sformatf("tbl%0d_regs", v), rg, tbl[v].exp_regs);
    end

    // Both requesters valid continuously: alternate grants 0,1,0,1.
    rr_exp = '{0, 1, 0, 1};
    for (int i = 0; i < NR; i++) begin
      t_write[i] = 1'b0; t_addr[i] = 4'd1;
    end
    for (int k = 0; k < 4; k++) begin
      txn(2'b11, 0, w, rd, er, rg);
      check($sformatf("rr%0d_win", k), 64'(w), 64'(rr_exp[k]));
    end

    // Response back-pressure for 5 cycles while the other requester waits.
    txn(2'b11, 5, w, rd, er, rg);
    check("stall_win", 64'(w), 64'd0);
    check("stall_rdata", 64'(rd), 64'hA5A5_0F0F);
    req_valid = '0;

    // Reset during ACCESS of a write: no commit, no response, rr back to 0.
    t_write[0] = 1'b1; t_addr[0] = 4'd1; t_wdata[0] = 32'hCAFE_F00D;
    apply(2'b01);
    @(negedge clk);
    check("abort_grant", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    apply(2'b00);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_regs", regs_out, 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    check("abort_no_resp", 64'(rsp_valid), 64'd0);
    check("abort_regs_hold", regs_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_word[0] = '0; m_word[1] = '0; m_rr = 0;
    @(posedge clk); #1;
    t_write[0] = 1'b0; t_write[1] = 1'b0; t_addr[0] = 4'd1; t_addr[1] = 4'd1;
    txn(2'b11, 0, w, rd, er, rg);
    check("post_abort_win", 64'(w), 64'd0);
    check("post_abort_rdata", 64'(rd), 64'd0);
    req_valid = '0;

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      vm = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        t_write[i] = 1'($urandom_range(0, 1));
        t_addr[i]  = AB'($urandom_range(0, 3));
        t_wdata[i] = $urandom;
      end
      txn(vm, $urandom_range(0, 3), w, rd, er, rg);
    end
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
